// File: rtl/fifo_read_ctrl_if.sv
// Downstream valid/ready stream for words drained from the FIFO.
// The controller drives it through the master modport.
interface fifo_read_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: burst/trickle read FSM.
// A 2-entry skid buffer hides the FIFO's 1-cycle read latency.
module fifo_read_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty_i,
  input  logic              fifo_threshold_i,
  input  logic              fifo_underflow_i,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  output logic              rd_o,
  fifo_read_ctrl_if.master  m_if,
  output logic              burst_active_o,
  input  logic              err_clr_i,
  output logic              err_underflow_o,
  output logic [15:0]       rd_count_o
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TRICKLE = 2'd1;
  localparam logic [1:0] BURST   = 2'd2;

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] BLEN = CW'(BURST_LEN);

  logic [1:0]        state_q, state_d;
  logic [1:0]        occ_q, occ_d;
  logic              infl_q;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [15:0]       cnt_q;
  logic              err_q;
  logic              pop;
  logic              can_rd;
  logic              rd;
  logic [2:0]        used;

  // Buffer slots already promised: held, in flight, minus the one leaving.
  assign pop    = (occ_q != 2'd0) && m_if.m_ready;
  assign used   = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
  assign can_rd = !fifo_empty_i && (used < 3'd2);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    rd      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty_i) begin
          state_d = fifo_threshold_i ? BURST : TRICKLE;
          bcnt_d  = '0;
        end
      end
      TRICKLE: begin
        rd = can_rd;
        if (fifo_empty_i || can_rd) state_d = IDLE;
      end
      BURST: begin
        rd = can_rd;
        if (can_rd) bcnt_d = bcnt_q + 1'b1;
        if (fifo_empty_i || (can_rd && bcnt_d == BLEN))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case (1'b1)
      infl_q && pop: begin
        head_d = (occ_q == 2'd2) ? tail_q : fifo_rdata_i;
        tail_d = fifo_rdata_i;
      end
      infl_q && !pop: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) head_d = fifo_rdata_i;
        else               tail_d = fifo_rdata_i;
      end
      !infl_q && pop: begin
        occ_d  = occ_q - 2'd1;
        head_d = tail_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q   <= '0;
      infl_q  <= 1'b0;
      bcnt_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      infl_q  <= rd;
      bcnt_q  <= bcnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (rd) cnt_q <= cnt_q + 16'd1;
      err_q   <= fifo_underflow_i | (err_q & ~err_clr_i);
    end
  end

  assign rd_o            = rd;
  assign m_if.m_valid    = (occ_q != 2'd0);
  assign m_if.m_data     = head_q;
  assign burst_active_o  = (state_q == BURST);
  assign err_underflow_o = err_q;
  assign rd_count_o      = cnt_q;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: FIFO model, stream scoreboard,
// directed vector tables and a randomized traffic phase.
module tb_fifo_read_ctrl;
  localparam int DW  = 8;
  localparam int BL  = 16;
  localparam int THR = 16;

  typedef struct packed {
    logic uf;
    logic clr;
    logic err;
  } err_vec_t;

  typedef struct packed {
    logic          rd;
    logic          v;
    logic [DW-1:0] d;
  } trk_vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty;
  logic          fifo_threshold;
  logic          fifo_underflow = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] fifo_rdata = '0;
  logic          rd;
  logic          burst_active;
  logic          err_underflow;
  logic [15:0]   rd_count;

  fifo_read_ctrl_if #(.DATA_W(DW)) sif ();

  fifo_read_ctrl #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_empty_i     (fifo_empty),
    .fifo_threshold_i (fifo_threshold),
    .fifo_underflow_i (fifo_underflow),
    .fifo_rdata_i     (fifo_rdata),
    .rd_o             (rd),
    .m_if             (sif),
    .burst_active_o   (burst_active),
    .err_clr_i        (err_clr),
    .err_underflow_o  (err_underflow),
    .rd_count_o       (rd_count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem [0:8191];
  int unsigned   wr_n = 0;
  int unsigned   rd_n = 0;
  logic          thr_force = 1'b0;
  logic [DW-1:0] exp_q [$];
  logic [31:0]   rd_cnt_m = '0;
  logic          err_m = 1'b0;
  logic          chk_en = 1'b0;

  assign fifo_empty     = (wr_n == rd_n);
  assign fifo_threshold = thr_force || ((wr_n - rd_n) >= THR);

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // FIFO storage model plus reference counters
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      rd_cnt_m <= '0;
      err_m    <= 1'b0;
    end else begin
      if (rd) begin
        fifo_rdata <= mem[rd_n[12:0]];
        exp_q.push_back(mem[rd_n[12:0]]);
        rd_n     <= rd_n + 1;
        rd_cnt_m <= rd_cnt_m + 1;
      end
      if (fifo_underflow) err_m <= 1'b1;
      else if (err_clr)   err_m <= 1'b0;
    end
  end

  logic          pv  = 1'b0;
  logic [DW-1:0] pd  = '0;
  logic          prd = 1'b0;
  int            run = 0;

  always @(negedge clk) begin
    if (rst || !chk_en) begin
      pv  = 1'b0;
      prd = 1'b0;
      run = 0;
    end else begin
      check("rd_when_empty", 32'(rd && fifo_empty), 0);
      if (pv) begin
        check("hold_valid", 32'(sif.m_valid), 1);
        check("hold_data", 32'(sif.m_data), 32'(pd));
      end
      if (sif.m_valid && sif.m_ready) begin
        check("beat_available", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          check("data_order", 32'(sif.m_data), 32'(exp_q.pop_front()));
      end
      check("rd_count", 32'(rd_count), 32'(rd_cnt_m[15:0]));
      check("err_flag", 32'(err_underflow), 32'(err_m));
      check("outstanding", 32'(exp_q.size() <= 2), 1);
      run = rd ? run + 1 : 0;
      check("burst_len_max", 32'(run <= BL), 1);
      if (rd && !burst_active) check("trickle_gap", 32'(prd), 0);
      pv  = sif.m_valid && !sif.m_ready;
      pd  = sif.m_data;
      prd = rd;
    end
  end

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    mem[wr_n[12:0]] = b;
    wr_n = wr_n + 1;
  endtask

  task automatic wait_idle(input string nm);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      done = fifo_empty && (exp_q.size() == 0) && !sif.m_valid &&
             !burst_active && !rd;
      n++;
    end
    check(nm, 32'(done), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    err_vec_t    ev [12];
    trk_vec_t    tv [9];
    int          n;
    logic [15:0] base;
    logic [15:0] diff;
    logic [31:0] rdv, bav, erd, eba;

    ev = '{
      '{1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b0}
    };
    tv = '{
      '{1'b0, 1'b0, 8'h00}, '{1'b1, 1'b0, 8'h00}, '{1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 8'hA1}, '{1'b0, 1'b0, 8'h00}, '{1'b1, 1'b1, 8'hA2},
      '{1'b0, 1'b0, 8'h00}, '{1'b0, 1'b1, 8'hA3}, '{1'b0, 1'b0, 8'h00}
    };

    sif.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd", 32'(rd), 0);
    check("rst_valid", 32'(sif.m_valid), 0);
    check("rst_data", 32'(sif.m_data), 0);
    check("rst_burst", 32'(burst_active), 0);
    check("rst_err", 32'(err_underflow), 0);
    check("rst_count", 32'(rd_count), 0);
    rst         = 1'b0;
    sif.m_ready = 1'b1;
    chk_en      = 1'b1;

    // error flag: set/clear/priority table
    @(negedge clk);
    foreach (ev[i]) begin
      fifo_underflow = ev[i].uf;
      err_clr        = ev[i].clr;
      @(negedge clk);
      check($sformatf("err_vec%0d", i), 32'(err_underflow), 32'(ev[i].err));
    end
    fifo_underflow = 1'b0;
    err_clr        = 1'b0;

    // trickle: three entries, threshold low
    after_pos();
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("t2_rd%0d", i), 32'(rd), 32'(tv[i].rd));
      check($sformatf("t2_valid%0d", i), 32'(sif.m_valid), 32'(tv[i].v));
      if (tv[i].v)
        check($sformatf("t2_data%0d", i), 32'(sif.m_data), 32'(tv[i].d));
    end
    wait_idle("t2_idle");

    // burst: 20 entries, 16-read episode, one idle cycle, then the rest
    after_pos();
    base      = rd_cnt_m[15:0];
    thr_force = 1'b1;
    for (int i = 0; i < 20; i++) push(8'($urandom));
    rdv = '0;
    bav = '0;
    erd = '0;
    eba = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      rdv[c] = rd;
      bav[c] = burst_active;
      erd[c] = (c >= 1 && c <= BL) || (c >= BL + 2 && c <= BL + 5);
      eba[c] = (c >= 1 && c <= BL) || (c >= BL + 2 && c <= BL + 6);
    end
    check("t3_rd_pattern", rdv, erd);
    check("t3_burst_pattern", bav, eba);
    thr_force = 1'b0;
    wait_idle("t3_idle");
    diff = rd_count - base;
    check("t3_rd_total", 32'(diff), 20);

    // backpressure mid-burst
    after_pos();
    thr_force = 1'b1;
    for (int i = 0; i < 20; i++) push(8'($urandom));
    repeat (6) @(negedge clk);
    after_pos();
    sif.m_ready = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd) n++;
    end
    check("t4_stall_rd", 32'(n <= 2), 1);
    check("t4_stall_valid", 32'(sif.m_valid), 1);
    after_pos();
    sif.m_ready = 1'b1;
    thr_force   = 1'b0;
    wait_idle("t4_drain");

    // FIFO runs empty mid-burst
    after_pos();
    thr_force = 1'b1;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd) n++;
    end
    check("t5_rd_total", 32'(n), 5);
    check("t5_burst_exit", 32'(burst_active), 0);
    thr_force = 1'b0;
    wait_idle("t5_idle");

    // reset mid-burst with the buffer full
    after_pos();
    thr_force   = 1'b1;
    sif.m_ready = 1'b0;
    for (int i = 0; i < 20; i++) push(8'($urandom));
    repeat (6) @(negedge clk);
    check("t1_pre_valid", 32'(sif.m_valid), 1);
    check("t1_pre_burst", 32'(burst_active), 1);
    after_pos();
    rst = 1'b1;
    #1;
    check("t1_rd", 32'(rd), 0);
    check("t1_valid", 32'(sif.m_valid), 0);
    check("t1_count", 32'(rd_count), 0);
    check("t1_burst", 32'(burst_active), 0);
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    sif.m_ready = 1'b1;
    wait_idle("t1_recover");
    thr_force = 1'b0;

    // randomized traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      after_pos();
      if ($urandom_range(99) < 45 && (wr_n - rd_n) < 32)
        push(8'($urandom));
      sif.m_ready    = ($urandom_range(99) < 70);
      fifo_underflow = ($urandom_range(99) < 2);
      err_clr        = ($urandom_range(99) < 5);
    end
    after_pos();
    fifo_underflow = 1'b0;
    err_clr        = 1'b0;
    sif.m_ready    = 1'b1;
    wait_idle("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
